mul_booth_seq: RTL

- Sequential signed multiplier for the ALU. Radix-4 Booth recoding retires 2 multiplier bits per clock.
- Counterpart of the combinational divider. Produces a 2*DATA_WIDTH result that the datapath splits into HI (upper half) and LO (lower half) of the product.
- Start/busy/done handshake, so the control unit can stall for DATA_WIDTH/2 cycles instead of paying a long combinational path.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/booth_r4_encoder.sv | 32 +++
 rtl/mul_booth_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   - mul_state_t   : state of the sequential multiplier (IDLE/CALC/DONE)
//   - BOOTH_*       : radix-4 Booth digit encoding, {sign, magnitude[1:0]}
//   - booth_recode  : 3-bit multiplier window -> Booth digit
//   - HI/LO split   : bit ranges of the upper and lower halves of a
//                     double-width result, shared with the divider and
//                     the register file
package alu_pkg;

    localparam int XLEN = 32;

    // {HI, LO} split of a 2*XLEN-bit product or quotient/remainder pair.
    localparam int HI_MSB = 2*XLEN - 1;
    localparam int HI_LSB = XLEN;
    localparam int LO_MSB = XLEN - 1;
    localparam int LO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Bit 2 is the sign, bits 1:0 the magnitude (0, 1 or 2).
    typedef logic [2:0] booth_digit_t;

    localparam booth_digit_t BOOTH_ZERO = 3'b000;
    localparam booth_digit_t BOOTH_POS1 = 3'b001;
    localparam booth_digit_t BOOTH_POS2 = 3'b010;
    localparam booth_digit_t BOOTH_NEG1 = 3'b101;
    localparam booth_digit_t BOOTH_NEG2 = 3'b110;

    // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*w2 + w1 + w0.
    function automatic booth_digit_t booth_recode(input logic [2:0] window);
        booth_digit_t digit;
        case (window)
            3'b001, 3'b010: digit = BOOTH_POS1;
            3'b011:         digit = BOOTH_POS2;
            3'b100:         digit = BOOTH_NEG2;
            3'b101, 3'b110: digit = BOOTH_NEG1;
            default:        digit = BOOTH_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth partial-product generator (combinational).
// Ports:
//   window          in  3        low three bits of the multiplier accumulator
//   multiplicand    in  W        signed operand A
//   partial_product out W+2      digit * A, sign-extended to W+2 bits
// W+2 bits are enough for the extreme case -2 * (-2^(W-1)) = 2^W.
import alu_pkg::*;

module booth_r4_encoder #(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic [2:0]            window,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    output logic [DATA_WIDTH+1:0] partial_product
);

    booth_digit_t          digit;
    logic [DATA_WIDTH+1:0] a_ext;
    logic [DATA_WIDTH+1:0] magnitude;

    always_comb begin
        digit = booth_recode(window);
        a_ext = {{2{multiplicand[DATA_WIDTH-1]}}, multiplicand};
        case (digit[1:0])
            2'b01:   magnitude = a_ext;
            2'b10:   magnitude = {a_ext[DATA_WIDTH:0], 1'b0};
            default: magnitude = '0;
        endcase
        partial_product = digit[2] ? -magnitude : magnitude;
    end

endmodule

// File: rtl/mul_booth_seq.sv
// Sequential signed multiplier, radix-4 Booth, two multiplier bits per clock.
// Ports:
//   clock         in   1     rising-edge clock
//   clear         in   1     synchronous active-high reset, beats start
//   start         in   1     request; operands latched when accepted (IDLE/DONE)
//   multiplicand  in   W     signed operand A
//   multiplier    in   W     signed operand B
//   busy          out  1     high while in CALC
//   done          out  1     one-cycle pulse when result is updated
//   result        out  2W    signed product {HI, LO}, held until next completion
//   state         out  enum  current FSM state, for observation
// Handshake: a request is taken on any edge where start=1 and state is IDLE
// or DONE; start has no effect in CALC. done marks the single cycle in which
// a fresh result is first visible. W must be even and >= 4.
import alu_pkg::*;

module mul_booth_seq #(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     multiplicand,
    input  logic [DATA_WIDTH-1:0]     multiplier,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   result,
    output mul_state_t                state
);

    localparam int STEPS = DATA_WIDTH / 2;
    localparam int CNT_W = $clog2(STEPS);
    localparam int UP_W  = DATA_WIDTH + 2;       // partial-product adder width
    localparam int ACC_W = 2*DATA_WIDTH + 3;     // {upper, B, guard}

    logic [DATA_WIDTH-1:0] a_reg;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_next;
    logic [UP_W-1:0]       partial_product;
    logic [UP_W-1:0]       upper_sum;
    logic [CNT_W-1:0]      count;
    logic                  last_step;

    booth_r4_encoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_encoder (
        .window          (acc[2:0]),
        .multiplicand    (a_reg),
        .partial_product (partial_product)
    );

    // Add the partial product into the upper part, then shift the whole
    // accumulator arithmetically so the next window sits at acc[2:0].
    // Bits shifted out of the bottom are the consumed multiplier bits; the
    // product accumulates from the top down into acc[2W:1].
    always_comb begin
        upper_sum = acc[ACC_W-1 -: UP_W] + partial_product;
        acc_next  = $signed({upper_sum, acc[DATA_WIDTH:0]}) >>> 2;
        last_step = (count == CNT_W'(STEPS - 1));
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
            acc    <= '0;
            a_reg  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= multiplicand;
                        count <= '0;
                        if (multiplicand == '0 || multiplier == '0) begin
                            // Zero operand: product known now, no CALC pass.
                            acc    <= '0;
                            result <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc   <= {{UP_W{1'b0}}, multiplier, 1'b0};
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        // Drop the guard bit; upper sign bits are redundant
                        // since the product always fits in 2W bits.
                        result <= acc_next[2*DATA_WIDTH:1];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
